// File: rtl/ks_pipe_adder.sv
// ks_pipe_adder
//   Pipelined Kogge-Stone parallel-prefix adder/subtractor with a valid/ready
//   stream interface. It accepts one beat per clock and returns one result per
//   clock while the consumer keeps out_ready high.
//
//   Parameters
//     WIDTH     operand width, a power of two in 2..64
//     PIPELINE  1: register after P/G, after every prefix level, and at the output
//               0: register after P/G and at the output only
//
//   Ports
//     clk, rst_n        rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready operand beat handshake
//     in_a, in_b        operands
//     in_cin            carry-in (ignored when in_sub=1)
//     in_sub            1 = A - B
//     out_valid/out_ready result handshake
//     out_sum           sum / difference, modulo 2^WIDTH
//     out_cout          carry out of the MSB (subtract: 1 = no borrow)
//     out_ovf           two's-complement overflow
//
//   Latency: PIPELINE ? log2(WIDTH)+2 : 2 cycles from acceptance to out_valid.
module ks_pipe_adder #(
    parameter int WIDTH    = 16,
    parameter int PIPELINE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("ks_pipe_adder: WIDTH must be a power of two in 2..64");
    end

    // The whole pipe moves as one: any stage advances only when the output
    // register is empty or being drained. This keeps in_ready free of any
    // path from in_valid.
    logic w_adv;
    logic r_out_v;

    assign w_adv    = !r_out_v || out_ready;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // Stage 0: operand conditioning and bitwise propagate/generate.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_b;
    logic             w_c0;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;

    assign w_b  = in_sub ? ~in_b : in_b;
    assign w_c0 = in_sub | in_cin;
    assign w_p  = in_a ^ w_b;
    // Carry-in is folded in as a generate at position -1, so the prefix
    // tree produces carries that already include it.
    always_comb begin
        w_g    = in_a & w_b;
        w_g[0] = w_g[0] | (w_p[0] & w_c0);
    end

    logic             r_s0_v;
    logic [WIDTH-1:0] r_s0_p;
    logic [WIDTH-1:0] r_s0_g;
    logic             r_s0_c0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_s0_v <= 1'b0;
        else if (w_adv) r_s0_v <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s0_p  <= w_p;
            r_s0_g  <= w_g;
            r_s0_c0 <= w_c0;
        end
    end

    // ------------------------------------------------------------------
    // Prefix tree. Index k of these buses is the input to level k; index
    // LEVELS is the finished prefix. The bitwise propagate (w_lp0) and c0
    // ride alongside because the final XOR needs them. Group propagate is
    // only needed as input to levels 0..LEVELS-1.
    // ------------------------------------------------------------------
    logic [LEVELS:0][WIDTH-1:0]   w_lg;
    logic [LEVELS-1:0][WIDTH-1:0] w_lp;
    logic [LEVELS:0][WIDTH-1:0]   w_lp0;
    logic [LEVELS:0]              w_lc0;
    logic [LEVELS:0]              w_lv;

    assign w_lg[0]  = r_s0_g;
    assign w_lp[0]  = r_s0_p;
    assign w_lp0[0] = r_s0_p;
    assign w_lc0[0] = r_s0_c0;
    assign w_lv[0]  = r_s0_v;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;

        logic [WIDTH-1:0] w_go;

        for (genvar i = 0; i < WIDTH; i++) begin : g_gbit
            if (i >= D) begin : g_cmb
                assign w_go[i] = w_lg[k][i] | (w_lp[k][i] & w_lg[k][i-D]);
            end else begin : g_pass
                assign w_go[i] = w_lg[k][i];
            end
        end

        // Group propagate for the next level; the last level has no consumer.
        if (k < LEVELS - 1) begin : g_prop
            logic [WIDTH-1:0] w_po;

            for (genvar i = 0; i < WIDTH; i++) begin : g_pbit
                if (i >= D) begin : g_cmb
                    assign w_po[i] = w_lp[k][i] & w_lp[k][i-D];
                end else begin : g_pass
                    assign w_po[i] = w_lp[k][i];
                end
            end

            if (PIPELINE != 0) begin : g_reg
                logic [WIDTH-1:0] r_p;
                always_ff @(posedge clk) begin
                    if (w_adv) r_p <= w_po;
                end
                assign w_lp[k+1] = r_p;
            end else begin : g_wire
                assign w_lp[k+1] = w_po;
            end
        end

        if (PIPELINE != 0) begin : g_reg
            logic             r_v;
            logic [WIDTH-1:0] r_g;
            logic [WIDTH-1:0] r_p0;
            logic             r_c0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     r_v <= 1'b0;
                else if (w_adv) r_v <= w_lv[k];
            end

            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_g  <= w_go;
                    r_p0 <= w_lp0[k];
                    r_c0 <= w_lc0[k];
                end
            end

            assign w_lg[k+1]  = r_g;
            assign w_lp0[k+1] = r_p0;
            assign w_lc0[k+1] = r_c0;
            assign w_lv[k+1]  = r_v;
        end else begin : g_wire
            assign w_lg[k+1]  = w_go;
            assign w_lp0[k+1] = w_lp0[k];
            assign w_lc0[k+1] = w_lc0[k];
            assign w_lv[k+1]  = w_lv[k];
        end
    end

    // ------------------------------------------------------------------
    // Final stage: carry into bit i is the prefix generate of bit i-1
    // (c0 for bit 0). Overflow compares carry into and out of the MSB.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    assign w_sum  = w_lp0[LEVELS] ^ {w_lg[LEVELS][WIDTH-2:0], w_lc0[LEVELS]};
    assign w_cout = w_lg[LEVELS][WIDTH-1];
    assign w_ovf  = w_cout ^ w_lg[LEVELS][WIDTH-2];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_adv) begin
            r_out_v <= w_lv[LEVELS];
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_ovf   <= w_ovf;
        end
    end

    assign out_valid = r_out_v;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Bench for ks_pipe_adder: three instances (16/pipelined, 32/combinational
// tree, 64/pipelined) share operand buses; each has its own valid/ready.
module tb_ks_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic        in_cin;
    logic        in_sub;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_cout;
    logic [2:0]  out_ovf;
    logic [15:0] s16;
    logic [31:0] s32;
    logic [63:0] s64;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t sb[$];

    always #5 clk = ~clk;

    ks_pipe_adder #(.WIDTH(16), .PIPELINE(1)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(s16),
        .out_cout(out_cout[0]), .out_ovf(out_ovf[0]));

    ks_pipe_adder #(.WIDTH(32), .PIPELINE(0)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(s32),
        .out_cout(out_cout[1]), .out_ovf(out_ovf[1]));

    ks_pipe_adder #(.WIDTH(64), .PIPELINE(1)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(s64),
        .out_cout(out_cout[2]), .out_ovf(out_ovf[2]));

    function automatic int wid(input int idx);
        return (idx == 0) ? 16 : (idx == 1) ? 32 : 64;
    endfunction

    function automatic logic [63:0] osum(input int idx);
        return (idx == 0) ? {48'b0, s16} : (idx == 1) ? {32'b0, s32} : s64;
    endfunction

    // Reference: plain wide integer addition, overflow from operand/result signs.
    function automatic res_t model(input int idx, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        int          w;
        logic [63:0] m;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [64:0] full;
        w    = wid(idx);
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        aa   = a & m;
        bb   = (sub ? ~b : b) & m;
        full = {1'b0, aa} + {1'b0, bb} + {64'b0, (sub | cin)};
        r.sum  = full[63:0] & m;
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
        return r;
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 3'b000) begin
            errors++; $display("FAIL reset_out_valid: got %b want 000", out_valid);
        end
        checks++;
        if (in_ready !== 3'b111) begin
            errors++; $display("FAIL reset_in_ready: got %b want 111", in_ready);
        end
        checks++;
        if (s16 !== 16'h0 || out_cout[0] !== 1'b0 || out_ovf[0] !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b want 0 0 0", s16, out_cout[0], out_ovf[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single beat into an idle pipe; measures cycles until out_valid.
    task automatic test_latency(input int idx, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub, input logic [63:0] esum,
                                input logic ecout, input logic eovf, input int elat, input string name);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid[idx] = 1'b1; out_ready[idx] = 1'b1;
        #1;
        checks++;
        if (in_ready[idx] !== 1'b1) begin
            errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready[idx]);
        end
        @(negedge clk);
        in_valid[idx] = 1'b0;
        n = 1;
        while (out_valid[idx] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != elat) begin
            errors++; $display("FAIL %s_latency: got %0d want %0d", name, n, elat);
        end
        checks++;
        if (osum(idx) !== esum || out_cout[idx] !== ecout || out_ovf[idx] !== eovf) begin
            errors++;
            $display("FAIL %s_result: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, osum(idx), out_cout[idx], out_ovf[idx], esum, ecout, eovf);
        end
        @(negedge clk);
    endtask

    // Streams nbeats random beats with a scoreboard; optional backpressure
    // (out_ready low in 3-cycle bursts) and leading all-ones corner beats.
    task automatic run_stream(input int idx, input int nbeats, input bit bp, input bit corner,
                              input string name);
        int          sent, got, cyc, burst;
        bit          have, stall_prev;
        logic [63:0] ra, rb, hold_sum;
        logic        rc, rs, hold_c, hold_o;
        res_t        e;
        sent = 0; got = 0; cyc = 0; burst = 0; have = 0; stall_prev = 0;
        ra = '0; rb = '0; rc = 0; rs = 0; hold_sum = '0; hold_c = 0; hold_o = 0;
        sb.delete();
        while ((sent < nbeats || got < sent) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
                checks++;
                if (out_valid[idx] !== 1'b1 || osum(idx) !== hold_sum ||
                    out_cout[idx] !== hold_c || out_ovf[idx] !== hold_o) begin
                    errors++;
                    $display("FAIL %s_stall_hold: v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                             name, out_valid[idx], osum(idx), out_cout[idx], out_ovf[idx], hold_sum, hold_c, hold_o);
                end
            end
            if (!have && sent < nbeats) begin
                if (corner && sent < 2) begin
                    ra = {64{1'b1}}; rb = {64{1'b1}}; rc = 1'b1; rs = (sent == 1);
                end else begin
                    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
                    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
                end
                have = 1;
            end
            in_valid[idx] = have; in_a = ra; in_b = rb; in_cin = rc; in_sub = rs;
            if (bp && burst > 0) begin
                out_ready[idx] = 1'b0; burst--;
            end else if (bp && $urandom_range(0, 4) == 0) begin
                out_ready[idx] = 1'b0; burst = 2;
            end else begin
                out_ready[idx] = 1'b1;
            end
            #1;
            checks++;
            if (in_ready[idx] !== !(out_valid[idx] && !out_ready[idx])) begin
                errors++;
                $display("FAIL %s_in_ready: got %b with out_valid=%b out_ready=%b",
                         name, in_ready[idx], out_valid[idx], out_ready[idx]);
            end
            if (out_valid[idx] && out_ready[idx]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL %s_extra_result: sum=%h with empty scoreboard", name, osum(idx));
                end else begin
                    e = sb.pop_front();
                    if (osum(idx) !== e.sum || out_cout[idx] !== e.cout || out_ovf[idx] !== e.ovf) begin
                        errors++;
                        $display("FAIL %s_result[%0d]: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 name, got, osum(idx), out_cout[idx], out_ovf[idx], e.sum, e.cout, e.ovf);
                    end
                end
                got++;
            end
            if (have && in_ready[idx]) begin
                sb.push_back(model(idx, ra, rb, rc, rs));
                sent++;
                have = 0;
            end
            stall_prev = out_valid[idx] && !out_ready[idx];
            hold_sum = osum(idx); hold_c = out_cout[idx]; hold_o = out_ovf[idx];
        end
        in_valid[idx] = 1'b0; out_ready[idx] = 1'b1;
        checks++;
        if (got != nbeats || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_count: got %0d results (%0d pending) want %0d in %0d cycles",
                     name, got, sb.size(), nbeats, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        run_stream(0, 20, 1'b1, 1'b0, "bp16");
    endtask

    task automatic test_reset_midstream();
        int stale;
        out_ready[0] = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
            in_cin = 1'b0; in_sub = 1'b0; in_valid[0] = 1'b1;
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre_valid: got %b want 1", out_valid[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || s16 !== 16'h0 || out_cout[0] !== 1'b0 ||
            out_ovf[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: v=%b sum=%h cout=%b ovf=%b rdy=%b want 0 0000 0 0 1",
                     out_valid[0], s16, out_cout[0], out_ovf[0], in_ready[0]);
        end
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        stale = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL rst_mid_stale: got %0d stale valid cycles want 0", stale);
        end
        test_latency(0, 64'h1234, 64'h4321, 1'b1, 1'b0, 64'h5556, 1'b0, 1'b0, 6, "rst_mid_next");
    endtask

    task automatic test_w32();
        test_latency(1, {64{1'b1}}, {64{1'b1}}, 1'b1, 1'b0, 64'hFFFF_FFFF, 1'b1, 1'b0, 2, "w32_lat");
        run_stream(1, 1000, 1'b1, 1'b1, "w32");
    endtask

    task automatic test_w64();
        test_latency(2, {64{1'b1}}, {64{1'b1}}, 1'b1, 1'b0, {64{1'b1}}, 1'b1, 1'b0, 8, "w64_lat");
        run_stream(2, 1000, 1'b1, 1'b1, "w64");
    endtask

    initial begin
        in_valid = 3'b000; out_ready = 3'b111;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        test_reset();
        test_latency(0, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0, 6, "add_carry");
        test_latency(0, 64'h0000, 64'h0001, 1'b0, 1'b1, 64'hFFFF, 1'b0, 1'b0, 6, "sub_borrow");
        test_latency(0, 64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, 6, "sub_ovf");
        test_latency(0, 64'h7FFF, 64'h0000, 1'b1, 1'b0, 64'h8000, 1'b0, 1'b1, 6, "add_cin_ovf");
        test_backpressure();
        test_reset_midstream();
        test_w32();
        test_w64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
